// File: rtl/base_pkg.sv
// Shared definitions for the base loader: 2-bit nucleotide codes,
// default vector lengths and the loader state encoding.
package base_pkg;

  localparam int REF_LEN_DEF  = 50;
  localparam int READ_LEN_DEF = 10;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_G = 2'b01;
  localparam logic [1:0] BASE_C = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_REF,
    ST_LOAD_READ,
    ST_READY,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/base_encoder.sv
// ASCII-to-2-bit nucleotide decoder; upper and lower case are both legal,
// any other byte clears legal.
module base_encoder
  import base_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [1:0] code,
  output logic       legal
);

  always_comb begin
    code  = BASE_A;
    legal = 1'b1;
    case (in_char)
      8'h41, 8'h61: code = BASE_A;
      8'h47, 8'h67: code = BASE_G;
      8'h43, 8'h63: code = BASE_C;
      8'h54, 8'h74: code = BASE_T;
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/base_loader.sv
// Streams ASCII bases into a packed reference vector followed by a packed
// short-read vector, then holds both stable and pulses start once.
module base_loader
  import base_pkg::*;
#(
  parameter int REF_LEN  = REF_LEN_DEF,
  parameter int READ_LEN = READ_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [7:0]            in_char,
  output logic                  in_ready,
  output logic [2*REF_LEN-1:0]  reference,
  output logic [2*READ_LEN-1:0] shortread,
  output logic [6:0]            base_count,
  output logic                  load_done,
  output logic                  start,
  output logic                  err
);

  localparam logic [6:0] REF_CNT   = 7'(REF_LEN);
  localparam logic [6:0] TOTAL_CNT = 7'(REF_LEN + READ_LEN);

  state_t                state_q, state_d;
  logic [2*REF_LEN-1:0]  ref_q, ref_d;
  logic [2*READ_LEN-1:0] read_q, read_d;
  logic [6:0]            count_q, count_d;
  logic                  done_q, done_d;
  logic                  start_q, start_d;
  logic                  err_q, err_d;

  logic [1:0] code;
  logic       legal;
  logic       xfer;

  base_encoder u_enc (
    .in_char (in_char),
    .code    (code),
    .legal   (legal)
  );

  assign in_ready = (state_q == ST_LOAD_REF) || (state_q == ST_LOAD_READ);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    read_d  = read_q;
    count_d = count_q;
    done_d  = done_q;
    start_d = 1'b0;
    err_d   = err_q;
    // A restart outranks any transfer in the same cycle; that character is lost.
    if (load) begin
      state_d = ST_LOAD_REF;
      ref_d   = '0;
      read_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (xfer) begin
      if (!legal) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        if (count_q != TOTAL_CNT) count_d = count_q + 7'd1;
        if (state_q == ST_LOAD_REF) begin
          ref_d = {ref_q[2*REF_LEN-3:0], code};
          if (count_q == REF_CNT - 7'd1) state_d = ST_LOAD_READ;
        end else begin
          read_d = {read_q[2*READ_LEN-3:0], code};
          if (count_q == TOTAL_CNT - 7'd1) begin
            state_d = ST_READY;
            done_d  = 1'b1;
            start_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ref_q   <= '0;
      read_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      read_q  <= read_d;
      count_q <= count_d;
      done_q  <= done_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign reference  = ref_q;
  assign shortread  = read_q;
  assign base_count = count_q;
  assign load_done  = done_q;
  assign start      = start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_base_loader.sv
// Scoreboard bench for base_loader: expected vectors are queued per load and
// compared whenever the DUT pulses start.
module tb_base_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_char = 8'h00;
  logic         in_ready;
  logic [99:0]  reference;
  logic [19:0]  shortread;
  logic [6:0]   base_count;
  logic         load_done;
  logic         start;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  logic [119:0] sb[$];

  string up_s = {"ACTGAGTCTCGATCCTAGGAATTCCAGTCAAGACTGGAGATCTGACCTGA", "GAGTCAGACC"};
  string lo_s = {"actgagtctcgatcctaggaattccagtcaagactggagatctgacctga", "gagtcagacc"};

  base_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .reference  (reference),
    .shortread  (shortread),
    .base_count (base_count),
    .load_done  (load_done),
    .start      (start),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: enc = 2'b00;
      8'h47, 8'h67: enc = 2'b01;
      8'h43, 8'h63: enc = 2'b10;
      8'h54, 8'h74: enc = 2'b11;
      default:      enc = 2'b00;
    endcase
  endfunction

  function automatic logic [99:0] ref_prefix(input string s, input int n);
    logic [99:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[97:0], enc(s[i])};
    return r;
  endfunction

  function automatic logic [19:0] read_exp(input string s);
    logic [19:0] r = '0;
    for (int i = 50; i < 60; i++) r = {r[17:0], enc(s[i])};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic send_chars(input string s, input int from, input int to, input bit toggle);
    for (int i = from; i < to; i++) begin
      if (toggle) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_char  = s[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},   128'(in_ready),   128'(0));
    chk({tag, "_ref"},   128'(reference),  128'(0));
    chk({tag, "_read"},  128'(shortread),  128'(0));
    chk({tag, "_cnt"},   128'(base_count), 128'(0));
    chk({tag, "_done"},  128'(load_done),  128'(0));
    chk({tag, "_start"}, 128'(start),      128'(0));
    chk({tag, "_err"},   128'(err),        128'(0));
  endtask

  // Start monitor: each pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (start === 1'b1) begin
        n_starts++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_start", 128'(1), 128'(0));
        end else begin
          logic [119:0] e;
          e = sb.pop_front();
          chk("sb_ref",  128'(reference), 128'(e[119:20]));
          chk("sb_read", 128'(shortread), 128'(e[19:0]));
          chk("sb_cnt",  128'(base_count), 128'(60));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [99:0] ref_hold;
    logic [19:0] read_hold;

    // Reset state
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // Uppercase full load
    do_load();
    chk("A_cnt0", 128'(base_count), 128'(0));
    chk("A_rdy",  128'(in_ready),   128'(1));
    sb.push_back({ref_prefix(up_s, 50), read_exp(up_s)});
    send_chars(up_s, 0, 60, 1'b0);
    chk("A_start",   128'(start),            128'(1));
    chk("A_done",    128'(load_done),        128'(1));
    chk("A_cnt",     128'(base_count),       128'(60));
    chk("A_ref_msb", 128'(reference[99:96]), 128'(4'h2));
    chk("A_ref_lsb", 128'(reference[1:0]),   128'(2'b00));
    chk("A_read",    128'(shortread),        128'(20'h4784A));
    tick();
    chk("A_start_off", 128'(start),     128'(0));
    chk("A_done_hold", 128'(load_done), 128'(1));

    // READY ignores in_valid
    ref_hold  = reference;
    read_hold = shortread;
    in_valid = 1'b1;
    in_char  = 8'h47;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("R_rdy",   128'(in_ready), 128'(0));
      chk("R_start", 128'(start),    128'(0));
    end
    in_valid = 1'b0;
    chk("R_ref",  128'(reference),  128'(ref_hold));
    chk("R_read", 128'(shortread),  128'(read_hold));
    chk("R_cnt",  128'(base_count), 128'(60));
    chk("R_done", 128'(load_done),  128'(1));

    // Lowercase, in_valid every other cycle
    do_load();
    chk("B_done_clr", 128'(load_done), 128'(0));
    sb.push_back({ref_prefix(up_s, 50), read_exp(up_s)});
    send_chars(lo_s, 0, 60, 1'b1);
    chk("B_start", 128'(start),     128'(1));
    chk("B_cnt",   128'(base_count), 128'(60));
    chk("B_read",  128'(shortread),  128'(20'h4784A));
    tick();
    chk("B_start_off", 128'(start), 128'(0));

    // Illegal character as base 12
    do_load();
    send_chars(up_s, 0, 11, 1'b0);
    in_valid = 1'b1;
    in_char  = 8'h4E;
    tick();
    chk("E_err", 128'(err),        128'(1));
    chk("E_rdy", 128'(in_ready),   128'(0));
    chk("E_cnt", 128'(base_count), 128'(11));
    chk("E_ref", 128'(reference),  128'(ref_prefix(up_s, 11)));
    in_char = 8'h41;
    tick();
    tick();
    in_valid = 1'b0;
    chk("E_cnt_hold", 128'(base_count), 128'(11));
    chk("E_done",     128'(load_done),  128'(0));
    do_load();
    chk("E_err_clr", 128'(err),        128'(0));
    chk("E_cnt_clr", 128'(base_count), 128'(0));
    chk("E_ref_clr", 128'(reference),  128'(0));

    // Reset mid-load after 30 bases
    send_chars(up_s, 0, 30, 1'b0);
    chk("M_cnt30", 128'(base_count), 128'(30));
    reset = 1'b1;
    #2;
    chk_all_zero("mrst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("M_no_start", 128'(start),    128'(0));
      chk("M_idle",     128'(in_ready), 128'(0));
    end
    do_load();
    sb.push_back({ref_prefix(up_s, 50), read_exp(up_s)});
    send_chars(up_s, 0, 60, 1'b0);
    chk("M_start", 128'(start), 128'(1));
    tick();

    // Load coincident with transfer of base 20
    do_load();
    send_chars(up_s, 0, 19, 1'b0);
    chk("L_cnt19", 128'(base_count), 128'(19));
    in_valid = 1'b1;
    in_char  = up_s[19];
    load     = 1'b1;
    tick();
    load     = 1'b0;
    in_valid = 1'b0;
    chk("L_cnt0", 128'(base_count), 128'(0));
    chk("L_ref0", 128'(reference),  128'(0));
    chk("L_rdy",  128'(in_ready),   128'(1));
    sb.push_back({ref_prefix(up_s, 50), read_exp(up_s)});
    send_chars(up_s, 0, 60, 1'b0);
    chk("L_start", 128'(start), 128'(1));
    tick();
    tick();

    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("n_starts", 128'(n_starts),  128'(4));
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
